mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 184 ++++++++++++++++++
 tb/tb_mdu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu -- multiply/divide unit holding the architectural HI/LO registers.
//
// Purpose:
//   Accepts one MDU instruction per start pulse while idle. Multiplies and
//   divides are computed combinationally from operands latched at the start
//   edge. A down-counter only models their latency: 5 cycles for the mult
//   class and 10 for the div class. HI/LO are written on the edge where the
//   counter goes 1->0. mthi/mtlo write immediately and never raise busy.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (clears counter, busy, hi, lo)
//   start    in   instruction valid, qualifies op; ignored while busy
//   op       in   [3:0] opcode: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, others no-op
//   a, b     in   [31:0] rs / rt operands
//   busy     out  multi-cycle operation in flight (registered, == counter!=0)
//   hi, lo   out  [31:0] architectural HI / LO
//
// Configuration:
//   MDU_MADD_EN  when defined, ops 7-10 (madd/maddu/msub/msubu) accumulate
//                into {hi,lo}; when undefined they are no-ops and no
//                accumulate hardware is built.

module mdu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] LAT_MUL = 4'd5;
    localparam logic [3:0] LAT_DIV = 4'd10;

    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // ------------------------------------------------------------------
    // Launch decode: latency to load for the incoming op (0 = no busy).
    // ------------------------------------------------------------------
    logic [3:0] launch_cnt;

    always_comb begin
        launch_cnt = 4'd0;
        case (op)
            OP_MULT, OP_MULTU: launch_cnt = LAT_MUL;
            OP_DIV,  OP_DIVU:  launch_cnt = LAT_DIV;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch_cnt = LAT_MUL;
`endif
            default: launch_cnt = 4'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath on latched operands.
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        is_signed = is_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    end

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // signed (sign-extended) or unsigned (zero-extended) 32x32 product.
    assign a_ext = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = a_ext * b_ext;

    // SV signed division truncates toward zero and the remainder follows
    // the dividend, which is exactly the required div semantics.
    assign quo_s = $signed(a_q) / $signed(b_q);
    assign rem_s = $signed(a_q) % $signed(b_q);
    assign quo_u = a_q / b_q;
    assign rem_u = a_q % b_q;

    logic        div_zero;
    logic        div_ovf;
    logic        res_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign div_zero = (b_q == 32'd0);
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // Accumulate ops read hi/lo at completion: nothing can write them while
    // busy and reset aborts the op, so this equals the start-edge value.
    always_comb begin
        res_wr = 1'b0;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = prod;
            end
            OP_DIV: begin
                res_wr = !div_zero && !div_ovf;
                res_hi = rem_s;
                res_lo = quo_s;
            end
            OP_DIVU: begin
                res_wr = !div_zero;
                res_hi = rem_u;
                res_lo = quo_u;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod;
            end
            OP_MSUB, OP_MSUBU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod;
            end
`endif
            default: res_wr = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State. busy is kept equal to (cnt != 0) by loading/clearing both
    // together, so it is a clean flop output for the stall controller.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= 4'd0;
            busy <= 1'b0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (busy) begin
            cnt  <= cnt - 4'd1;
            busy <= (cnt != 4'd1);
            if (cnt == 4'd1 && res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (start) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (launch_cnt != 4'd0) begin
                cnt  <= launch_cnt;
                busy <= 1'b1;
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- randomized scoreboard bench for mdu.
// Each issued op pushes its expected hi/lo and busy length into a queue; a
// monitor pops on the accepting edge and checks hold values while busy and
// the final hi/lo plus busy-cycle count when busy drops.

`timescale 1ns/1ps

module tb_mdu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    bit          active = 1'b0;
    int          bcnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one op on HI/LO, plus the
    // number of busy cycles it costs.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l, output int lat);
        longint sx, sy, mx, my, q, r;
        logic [63:0] p, acc;
        lat = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd1: begin p = sx * sy; {h, l} = p; lat = 5; end
            4'd2: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; lat = 5; end
            4'd3: begin
                lat = 10;
                if (y != 0 && !(x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
                    mx = (sx < 0) ? -sx : sx;
                    my = (sy < 0) ? -sy : sy;
                    q = mx / my;
                    r = mx % my;
                    if ((sx < 0) != (sy < 0)) q = -q;
                    if (sx < 0) r = -r;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            4'd4: begin
                lat = 10;
                if (y != 0) begin l = x / y; h = x % y; end
            end
            4'd5: h = x;
            4'd6: l = x;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                lat = 5;
                p = (o == 4'd7 || o == 4'd9) ? sx * sy : {32'd0, x} * {32'd0, y};
                acc = {h, l};
                acc = (o <= 4'd8) ? acc + p : acc - p;
                {h, l} = acc;
            end
`endif
            default: ;
        endcase
    endfunction

    // Monitor: pop on the accepting edge, check on the following negedges.
    initial begin
        forever begin
            @(posedge clk);
            if (reset_n && start && !busy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_accept: got op %0d expected no accept", op);
                end else begin
                    cur = sb.pop_front();
                    active = 1'b1;
                    bcnt = 0;
                end
            end
            @(negedge clk);
            if (!reset_n) begin
                active = 1'b0;
            end else if (active) begin
                if (busy) begin
                    bcnt++;
                    check("hold_hi", hi, cur.old_hi);
                    check("hold_lo", lo, cur.old_lo);
                    if (bcnt > 20) begin
                        check("busy_runaway", bcnt, cur.lat);
                        active = 1'b0;
                    end
                end else begin
                    check("busy_cycles", bcnt, cur.lat);
                    check("res_hi", hi, cur.exp_hi);
                    check("res_lo", lo, cur.exp_lo);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((active || sb.size() != 0) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (active || sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got still busy after %0d cycles expected idle", k);
            sb.delete();
        end
    endtask

    // Called at a negedge; drives start for one edge. wait_done=0 lets the
    // caller chain another op on the very next edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit wait_done);
        exp_t e;
        int lat;
        e.op = o;
        e.old_hi = m_hi;
        e.old_lo = m_lo;
        model(o, x, y, m_hi, m_lo, lat);
        e.exp_hi = m_hi;
        e.exp_lo = m_lo;
        e.lat = lat;
        sb.push_back(e);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'($urandom_range(0, 15));
        if (wait_done) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx, ry;

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First edge after reset release is a normal sampling edge.
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        issue(4'd4, 32'd7, 32'd0, 1'b1);
        check("divu0_hi", hi, 32'hFFFF_FFFF);
        check("divu0_lo", lo, 32'hFFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("divovf_lo", lo, 32'hFFFF_FFFD);

        // Back-to-back mthi/mtlo.
        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_busy", busy, 1'b0);
        issue(4'd6, 32'h0000_0009, 32'd0, 1'b1);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_lo", lo, 32'h0000_0009);

        // maddu accumulate, or no-op without the accumulate option.
        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(4'd8, 32'd1, 32'd1, 1'b1);
`ifdef MDU_MADD_EN
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset in busy cycle 4 of a div: immediate clear, no late write.
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        // start during busy is ignored.
        issue(4'd1, 32'd3, 32'd5, 1'b0);
        op = 4'd5;
        a = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd15);

        // Random ops, including div-by-zero and the signed overflow pair.
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            if (ro == 4'd3 && $urandom_range(0, 7) == 0) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 20));
            issue(ro, rx, ry, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
